cic_comp_fir_dec2: RTL and testbench



---
 rtl/cic_comp_pkg.sv | 34 +++
 rtl/cic_comp_fir_dec2_coef_rom.sv | 11 +
 rtl/cic_comp_fir_dec2.sv | 166 ++++++++++++++++
 tb/tb_cic_comp_fir_dec2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared constants, FSM state type and coefficient table for the CIC compensation FIR
package cic_comp_pkg;

    localparam int COEF_WIDTH_P = 16;
    localparam int NTAPS_P      = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Symmetric Q1.15 droop-compensation taps; only h[0..10] are stored, h[k] = h[20-k].
    // Taps outside 0..20 read as zero.
    function automatic logic signed [COEF_WIDTH_P-1:0] coef(input logic [4:0] k);
        logic [4:0] m;
        m = (k > 5'd10) ? (5'd20 - k) : k;
        case (m)
            5'd0:    coef = -16'sd20;
            5'd1:    coef = 16'sd35;
            5'd2:    coef = 16'sd60;
            5'd3:    coef = -16'sd110;
            5'd4:    coef = -16'sd150;
            5'd5:    coef = 16'sd260;
            5'd6:    coef = 16'sd330;
            5'd7:    coef = -16'sd600;
            5'd8:    coef = -16'sd700;
            5'd9:    coef = 16'sd1900;
            5'd10:   coef = 16'sd31000;
            default: coef = '0;
        endcase
    endfunction

endpackage

// File: rtl/cic_comp_fir_dec2_coef_rom.sv
// rtl/cic_comp_fir_dec2_coef_rom.sv - combinational tap-index to coefficient lookup
module cic_comp_coef_rom
    import cic_comp_pkg::*;
(
    input  logic [4:0]                     k_i,
    output logic signed [COEF_WIDTH_P-1:0] h_o
);

    assign h_o = coef(k_i);

endmodule

// File: rtl/cic_comp_fir_dec2.sv
// rtl/cic_comp_fir_dec2.sv - decimate-by-2 CIC droop-compensation FIR with a single time-multiplexed MAC
module cic_comp_fir_dec2
    import cic_comp_pkg::*;
#(
    parameter int INPUT_WIDTH  = 38,
    parameter int OUTPUT_WIDTH = 24,
    parameter int COEF_WIDTH   = COEF_WIDTH_P,
    parameter int NTAPS        = NTAPS_P,
    parameter int SHIFT        = 29
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           nd,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           rdy,
    output logic                           busy,
    output logic                           overrun
);

    localparam int ACC_W  = INPUT_WIDTH + COEF_WIDTH + 5;
    localparam int PROD_W = INPUT_WIDTH + COEF_WIDTH;
    // One guard bit above the wider of accumulator and output so rounding and limits never wrap.
    localparam int EXT_W  = ((ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH) + 1;
    localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;

    localparam logic signed [EXT_W-1:0] ONE     = 1;
    localparam logic signed [EXT_W-1:0] RND     = (SHIFT > 0) ? (ONE <<< RND_SH) : '0;
    localparam logic signed [EXT_W-1:0] SAT_MAX = (ONE <<< (OUTPUT_WIDTH - 1)) - ONE;
    localparam logic signed [EXT_W-1:0] SAT_MIN = -(ONE <<< (OUTPUT_WIDTH - 1));
    localparam logic [4:0]              LAST_K  = 5'(NTAPS - 1);

    logic signed [INPUT_WIDTH-1:0]  mem_q [32];
    logic [4:0]                     wptr_q, wptr_d;
    logic                           phase_q, phase_d;
    state_e                         state_q, state_d;
    logic [4:0]                     k_q, k_d;
    logic [4:0]                     base_q, base_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [OUTPUT_WIDTH-1:0] dout_q, dout_d;
    logic                           rdy_q, rdy_d;
    logic                           ovr_q, ovr_d;

    logic signed [COEF_WIDTH_P-1:0] h_rom;
    logic signed [COEF_WIDTH-1:0]   h;
    logic [4:0]                     rd_idx;
    logic signed [INPUT_WIDTH-1:0]  rd_data;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        acc_base;
    logic signed [EXT_W-1:0]        acc_ext;
    logic signed [EXT_W-1:0]        r;
    logic                           trig;

    cic_comp_coef_rom u_rom (
        .k_i (k_q),
        .h_o (h_rom)
    );

    assign h        = COEF_WIDTH'(h_rom);
    // Newest sample sits at base; older ones walk backwards, wrapping through the 32-entry ring.
    assign rd_idx   = base_q - k_q;
    assign rd_data  = mem_q[rd_idx];
    assign prod     = rd_data * h;
    assign acc_base = (k_q == 5'd0) ? '0 : acc_q;
    assign acc_ext  = EXT_W'(acc_q);
    assign r        = (acc_ext + RND) >>> SHIFT;
    assign trig     = nd & phase_q;

    // Sample ring: every strobe is written regardless of what the MAC is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (nd) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Next-state logic: pointer/phase tracking, MAC sequencing, output rounding and saturation.
    always_comb begin
        wptr_d  = wptr_q;
        phase_d = phase_q;
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        ovr_d   = ovr_q;

        if (nd) begin
            wptr_d  = wptr_q + 5'd1;
            phase_d = ~phase_q;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = MAC;
                    base_d  = wptr_q;
                    k_d     = 5'd0;
                end
            end
            MAC: begin
                if (trig) begin
                    ovr_d = 1'b1;
                end
                acc_d = acc_base + ACC_W'(prod);
                if (k_q == LAST_K) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            OUT: begin
                if (trig) begin
                    ovr_d = 1'b1;
                end
                if (r > SAT_MAX) begin
                    dout_d = OUTPUT_WIDTH'(SAT_MAX);
                end else if (r < SAT_MIN) begin
                    dout_d = OUTPUT_WIDTH'(SAT_MIN);
                end else begin
                    dout_d = r[OUTPUT_WIDTH-1:0];
                end
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            phase_q <= 1'b0;
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            phase_q <= phase_d;
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout    = dout_q;
    assign rdy     = rdy_q;
    assign busy    = (state_q != IDLE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir_dec2.sv
// tb/tb_cic_comp_fir_dec2.sv - self-checking bench for cic_comp_fir_dec2 at two parameter sets
module tb_cic_comp_fir_dec2;

    typedef struct {
        longint val;
        int     due;
    } sb_t;

    typedef struct {
        longint din;
        longint exp;
    } dc_vec_t;

    logic               clk;
    logic               rst;
    logic               nd;
    logic signed [37:0] din;
    logic signed [63:0] dout_a;
    logic               rdy_a, busy_a, ovr_a;
    logic signed [23:0] dout_b;
    logic               rdy_b, busy_b, ovr_b;

    int H [21] = '{-20, 35, 60, -110, -150, 260, 330, -600, -700, 1900, 31000,
                   1900, -700, -600, 330, 260, -150, -110, 60, 35, -20};

    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     last_acc = -1000;
    bit     ph       = 1'b0;
    bit     exp_ovr  = 1'b0;
    longint xs [$];
    sb_t    qa [$];
    sb_t    qb [$];
    dc_vec_t dc_tab [10];

    cic_comp_fir_dec2 #(.OUTPUT_WIDTH(64), .SHIFT(0)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .nd      (nd),
        .din     (din),
        .dout    (dout_a),
        .rdy     (rdy_a),
        .busy    (busy_a),
        .overrun (ovr_a)
    );

    cic_comp_fir_dec2 dut_b (
        .clk     (clk),
        .rst     (rst),
        .nd      (nd),
        .din     (din),
        .dout    (dout_b),
        .rdy     (rdy_b),
        .busy    (busy_b),
        .overrun (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint model_acc();
        longint a;
        int     n;
        a = 0;
        n = xs.size();
        for (int k = 0; k < 21; k++) begin
            if (n - 1 - k >= 0) a += longint'(H[k]) * xs[n-1-k];
        end
        return a;
    endfunction

    function automatic longint scale(input longint acc, input int sh, input int ow);
        longint r;
        longint lim;
        r = (sh > 0) ? ((acc + (64'sd1 <<< (sh - 1))) >>> sh) : acc;
        if (ow < 64) begin
            lim = 64'sd1 <<< (ow - 1);
            if (r > lim - 1) r = lim - 1;
            if (r < -lim) r = -lim;
        end
        return r;
    endfunction

    // Advance one clock, sample away from the edge and retire any result the DUTs present.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_a) begin
            if (qa.size() == 0) begin
                cmp("rdy_a_unexpected", longint'(rdy_a), 0);
            end else begin
                e = qa.pop_front();
                cmp("dout_a", dout_a, e.val);
                cmp("latency_a", cyc, e.due);
            end
        end else if (qa.size() > 0 && cyc > qa[0].due) begin
            cmp("rdy_a_by_due", longint'(rdy_a), 1);
            e = qa.pop_front();
        end
        if (rdy_b) begin
            if (qb.size() == 0) begin
                cmp("rdy_b_unexpected", longint'(rdy_b), 0);
            end else begin
                e = qb.pop_front();
                cmp("dout_b", longint'(dout_b), e.val);
                cmp("latency_b", cyc, e.due);
            end
        end else if (qb.size() > 0 && cyc > qb[0].due) begin
            cmp("rdy_b_by_due", longint'(rdy_b), 1);
            e = qb.pop_front();
        end
    endtask

    // Drive one sample; on an even sample the model predicts the result if the DUT should be idle.
    task automatic send(input longint x, input int gap);
        sb_t e;
        nd  = 1'b1;
        din = x[37:0];
        xs.push_back(x);
        if (ph) begin
            if (cyc >= last_acc + 23) begin
                e.due = cyc + 23;
                e.val = scale(model_acc(), 0, 64);
                qa.push_back(e);
                e.val = scale(model_acc(), 29, 24);
                qb.push_back(e);
                last_acc = cyc;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        ph = ~ph;
        tick();
        nd  = 1'b0;
        din = '0;
        repeat (gap - 1) tick();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        cmp("queue_a_empty", qa.size(), 0);
        cmp("queue_b_empty", qb.size(), 0);
        cmp("overrun_a", longint'(ovr_a), longint'(exp_ovr));
        cmp("overrun_b", longint'(ovr_b), longint'(exp_ovr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nd  = 1'b0;
        din = '0;
        xs.delete();
        qa.delete();
        qb.delete();
        ph       = 1'b0;
        last_acc = -1000;
        exp_ovr  = 1'b0;
        tick();
        tick();
        cmp("rst_dout_a", dout_a, 0);
        cmp("rst_dout_b", longint'(dout_b), 0);
        cmp("rst_rdy_b", longint'(rdy_b), 0);
        cmp("rst_busy_a", longint'(busy_a), 0);
        cmp("rst_busy_b", longint'(busy_b), 0);
        cmp("rst_ovr_a", longint'(ovr_a), 0);
        cmp("rst_ovr_b", longint'(ovr_b), 0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        dc_tab[0] = '{1000,               0};
        dc_tab[1] = '{64'sd1 <<< 30,      66020};
        dc_tab[2] = '{-(64'sd1 <<< 30),   -66020};
        dc_tab[3] = '{5 * (64'sd1 <<< 26), 20631};
        dc_tab[4] = '{-5 * (64'sd1 <<< 26), -20631};
        dc_tab[5] = '{3 * (64'sd1 <<< 26), 12379};
        dc_tab[6] = '{-3 * (64'sd1 <<< 26), -12379};
        dc_tab[7] = '{(64'sd1 <<< 37) - 1, 8388607};
        dc_tab[8] = '{-(64'sd1 <<< 37),   -8388608};
        dc_tab[9] = '{0,                  0};

        rst = 1'b1;
        nd  = 1'b0;
        din = '0;
        do_reset();

        // Impulse: SHIFT=0 instance returns odd taps h[1], h[3], ... then zero.
        send(1, 12);
        for (int i = 1; i < 24; i++) send(0, 12);
        drain(30);

        // DC table: each level held for 24 samples, final output checked against the settled value.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 24; i++) send(dc_tab[v].din, 12);
            repeat (15) tick();
            cmp($sformatf("dc_settled_%0d", v), longint'(dout_b), dc_tab[v].exp);
        end
        drain(10);

        // Triggers every 10 clk: the in-flight result is delivered, overrun latches and stays.
        do_reset();
        for (int i = 0; i < 8; i++) send(longint'($urandom_range(0, 200000)) - 100000, 5);
        drain(40);
        repeat (30) tick();
        cmp("overrun_sticky_b", longint'(ovr_b), 1);

        // Reset 10 clk into a computation: no result, clean restart on the 2nd new sample.
        do_reset();
        send(12345, 1);
        send(-6789, 1);
        repeat (9) tick();
        cmp("busy_mid_mac_a", longint'(busy_a), 1);
        cmp("busy_mid_mac_b", longint'(busy_b), 1);
        do_reset();
        for (int i = 0; i < 6; i++) send(longint'(i) * 1000003, 12);
        drain(30);

        // Ramp across the write-pointer wrap.
        do_reset();
        for (int n = 1; n <= 44; n++) send(longint'(n) * 4097, 12);
        drain(30);

        // Back-to-back strobes: each writes a sample, second trigger is dropped.
        do_reset();
        for (int i = 0; i < 6; i++) send(longint'(i + 1) * 99991, 1);
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
